// File: rtl/passageway_pkg.sv
// ============================================================================
//  Module      : passageway_pkg
//  Description : Shared types, constants and zone decode for the passageway
//                plant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package passageway_pkg;

    typedef enum logic [1:0] {
        CORRIDOR = 2'd0,
        OPEN     = 2'd1,
        DOORSTEP = 2'd2
    } level_t;

    typedef logic [1:0] zone_t;

    localparam int    NZONES    = 4;
    localparam zone_t GOAL_ZONE = 2'd3;

    function automatic logic [NZONES-1:0] zone_onehot(input zone_t z);
        return NZONES'(1) << z;
    endfunction

endpackage

`default_nettype wire

// File: rtl/passageway_door_timer.sv
// ============================================================================
//  Module      : passageway_door_timer
//  Description : Counts consecutive cycles the door rests in OPEN and flags
//                the cycle on which it must auto-close.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module passageway_door_timer #(
    parameter int DOOR_TIMEOUT = 4,
    parameter int TW           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [TW-1:0] c_LAST = TW'(DOOR_TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/passageway_plant.sv
// ============================================================================
//  Module      : passageway_plant
//  Description : Cycle-accurate passageway plant; controllable_* outputs are
//                the decoded successor state (Mealy). Optional fault path
//                enabled by PASSAGEWAY_FAULT_INJECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module passageway_plant
    import passageway_pkg::*;
#(
    parameter int DOOR_TIMEOUT = 4,
    parameter int TW           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic iup,
    input  logic iright,
`ifdef PASSAGEWAY_FAULT_INJECT_EN
    input  logic fault_inj,
`endif
    output logic controllable_zone0,
    output logic controllable_zone1,
    output logic controllable_zone2,
    output logic controllable_zone3,
    output logic controllable_open,
    output logic controllable_doorstep,
    output logic controllable_fault,
    output logic at_goal
);

    level_t              r_level;
    level_t              w_level_nxt;
    zone_t               r_zone;
    zone_t               w_zone_nxt;
    logic                w_fault_nxt;
    logic                w_timer_inc;
    logic                w_expired;
    logic                r_at_goal;
    logic [NZONES-1:0]   w_zone_oh;

`ifdef PASSAGEWAY_FAULT_INJECT_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end

    // The request is visible in the successor state of the same cycle.
    assign w_fault_nxt = r_fault | fault_inj;
`else
    assign w_fault_nxt = 1'b0;
`endif

    passageway_door_timer #(
        .DOOR_TIMEOUT (DOOR_TIMEOUT),
        .TW           (TW)
    ) u_door_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (~w_timer_inc),
        .i_inc     (w_timer_inc),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= CORRIDOR;
            r_zone    <= '0;
            r_at_goal <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_zone    <= w_zone_nxt;
            r_at_goal <= (w_zone_nxt == GOAL_ZONE) && !w_fault_nxt;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        w_zone_nxt  = r_zone;
        unique case (r_level)
            CORRIDOR: begin
                if (!iup) w_level_nxt = OPEN;
            end
            OPEN: begin
                if (iup)            w_level_nxt = CORRIDOR;
                else if (iright)    w_level_nxt = DOORSTEP;
                else if (w_expired) w_level_nxt = CORRIDOR;
            end
            DOORSTEP: begin
                if (iright) begin
                    if ((r_zone != GOAL_ZONE) && !w_fault_nxt) begin
                        w_zone_nxt = r_zone + 2'd1;
                    end
                end else if (iup) begin
                    w_level_nxt = OPEN;
                end
            end
            default: w_level_nxt = CORRIDOR;
        endcase
    end

    // Timer only runs while the door rests in OPEN; any entry restarts it.
    assign w_timer_inc = (r_level == OPEN) && (w_level_nxt == OPEN);

    assign w_zone_oh = zone_onehot(w_zone_nxt);

    assign controllable_zone0    = rst | w_zone_oh[0];
    assign controllable_zone1    = ~rst & w_zone_oh[1];
    assign controllable_zone2    = ~rst & w_zone_oh[2];
    assign controllable_zone3    = ~rst & w_zone_oh[3];
    assign controllable_open     = ~rst & ((w_level_nxt == OPEN) || (w_level_nxt == DOORSTEP));
    assign controllable_doorstep = ~rst & (w_level_nxt == DOORSTEP);
    assign controllable_fault    = ~rst & w_fault_nxt;
    assign at_goal               = r_at_goal;

endmodule

`default_nettype wire

// File: tb/tb_passageway_plant.sv
// ============================================================================
//  Module      : tb_passageway_plant
//  Description : Directed + random bench for passageway_plant against a
//                behavioural model of the passageway.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_passageway_plant;

    localparam int DT = 4;

    logic clk = 1'b0;
    logic rst, iup, iright, fault_inj;
    logic z0, z1, z2, z3, c_open, c_door, c_fault, at_goal;

    int total = 0;
    int bad   = 0;

    // model state: level 0=corridor 1=open 2=doorstep; open_for = cycles the door has rested open
    int m_zone, m_level, m_open_for, m_fault;
    int n_zone, n_level, n_open_for, n_fault;
    logic [3:0] last_zones;
    logic       last_open, last_door, last_fault;

    always #5 clk = ~clk;

    passageway_plant #(.DOOR_TIMEOUT(DT), .TW(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .iup                   (iup),
        .iright                (iright),
`ifdef PASSAGEWAY_FAULT_INJECT_EN
        .fault_inj             (fault_inj),
`endif
        .controllable_zone0    (z0),
        .controllable_zone1    (z1),
        .controllable_zone2    (z2),
        .controllable_zone3    (z3),
        .controllable_open     (c_open),
        .controllable_doorstep (c_door),
        .controllable_fault    (c_fault),
        .at_goal               (at_goal)
    );

    task automatic chk(input logic [3:0] obs, input logic [3:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_next(input logic u, input logic r, input logic rs, input logic f);
        n_zone = m_zone; n_level = m_level; n_open_for = m_open_for;
        n_fault = (m_fault != 0 || f) ? 1 : 0;
        if (rs) begin
            n_zone = 0; n_level = 0; n_open_for = 0; n_fault = 0;
        end else if (m_level == 0) begin
            if (!u) begin n_level = 1; n_open_for = 0; end
        end else if (m_level == 1) begin
            if (u)                        n_level = 0;
            else if (r)                   n_level = 2;
            else if (m_open_for + 1 >= DT) n_level = 0;
            else                          n_open_for = m_open_for + 1;
        end else begin
            if (r) begin
                if (m_zone < 3 && n_fault == 0) n_zone = m_zone + 1;
            end else if (u) begin
                n_level = 1; n_open_for = 0;
            end
        end
    endtask

    task automatic step(input logic u, input logic r, input logic rs, input logic f, input string tag);
        logic [3:0] ez;
        @(negedge clk);
        iup = u; iright = r; rst = rs; fault_inj = f;
        #1;
        model_next(u, r, rs, f);
`ifndef PASSAGEWAY_FAULT_INJECT_EN
        n_fault = 0;
`endif
        ez = 4'd1 << n_zone;
        last_zones = {z3, z2, z1, z0};
        last_open = c_open; last_door = c_door; last_fault = c_fault;
        chk(last_zones, ez, {tag, "_zone"});
        chk({3'b0, $onehot(last_zones)}, 4'd1, {tag, "_onehot"});
        chk({3'b0, c_open}, {3'b0, n_level != 0}, {tag, "_open"});
        chk({3'b0, c_door}, {3'b0, n_level == 2}, {tag, "_doorstep"});
        chk({3'b0, c_fault}, {3'b0, n_fault != 0}, {tag, "_fault"});
        @(posedge clk);
        m_zone = n_zone; m_level = n_level; m_open_for = n_open_for; m_fault = n_fault;
        #1;
        chk({3'b0, at_goal}, {3'b0, (m_zone == 3 && m_fault == 0)}, {tag, "_at_goal"});
    endtask

    initial begin
        rst = 1'b1; iup = 1'b1; iright = 1'b0; fault_inj = 1'b0;
        m_zone = 0; m_level = 0; m_open_for = 0; m_fault = 0;

        step(1, 0, 1, 0, "reset");
        step(0, 1, 1, 0, "reset_forced");
        chk(last_zones, 4'b0001, "reset_decode_zone");
        chk({3'b0, last_open}, 4'd0, "reset_decode_open");

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "corridor_up");
        chk({3'b0, last_open}, 4'd0, "corridor_up_no_open");

        step(0, 0, 0, 0, "enter_open");
        chk({3'b0, last_open}, 4'd1, "enter_open_direct");
        step(0, 1, 0, 0, "enter_doorstep");
        chk({3'b0, last_door}, 4'd1, "enter_doorstep_direct");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "advance");
        chk(last_zones, 4'b1000, "reach_zone3");
        step(0, 1, 0, 0, "saturate");
        chk(last_zones, 4'b1000, "saturate_zone3");
        chk({3'b0, at_goal}, 4'd1, "at_goal_direct");

        // auto-close after DT hold cycles
        step(1, 0, 0, 0, "door_to_open");
        for (int i = 0; i < DT - 1; i++) step(0, 0, 0, 0, "hold");
        chk({3'b0, last_open}, 4'd1, "hold_still_open");
        step(0, 0, 0, 0, "autoclose");
        chk({3'b0, last_open}, 4'd0, "autoclose_direct");

        // expiry cycle with iright: doorstep wins
        step(0, 0, 0, 0, "reopen");
        for (int i = 0; i < DT - 1; i++) step(0, 0, 0, 0, "hold2");
        step(0, 1, 0, 0, "expiry_right");
        chk({3'b0, last_door}, 4'd1, "expiry_right_direct");

        // reset mid-episode at doorstep zone 2
        step(1, 0, 1, 0, "reset2");
        step(0, 0, 0, 0, "r2_open");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "r2_adv");
        chk(last_zones, 4'b0100, "r2_zone2");
        step(0, 1, 1, 0, "mid_reset");
        chk(last_zones, 4'b0001, "mid_reset_zone0");
        chk({3'b0, last_open}, 4'd0, "mid_reset_open");
        step(1, 0, 0, 0, "post_reset");

`ifdef PASSAGEWAY_FAULT_INJECT_EN
        step(0, 0, 0, 0, "f_open");
        step(0, 1, 0, 0, "f_door");
        step(0, 1, 0, 0, "f_zone1");
        step(0, 0, 0, 1, "f_inject");
        chk({3'b0, last_fault}, 4'd1, "fault_immediate");
        step(0, 1, 0, 0, "f_adv1");
        step(0, 1, 0, 0, "f_adv2");
        chk(last_zones, 4'b0010, "fault_zone_held");
        chk({3'b0, last_fault}, 4'd1, "fault_sticky");
`endif

        for (int i = 0; i < 500; i++) begin
            logic rr, ff;
            rr = ($urandom_range(0, 24) == 0);
`ifdef PASSAGEWAY_FAULT_INJECT_EN
            ff = ($urandom_range(0, 40) == 0);
`else
            ff = 1'b0;
`endif
            step(1'($urandom), 1'($urandom), rr, ff, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/passageway_plant.md
# passageway_plant

- Cycle-accurate plant model of the passageway the agent walks through, i.e. the system under test.
- Consumes the agent's move bits `iup`/`iright` and produces the `controllable_*` observation bits that the passageway requirement monitor reads on the same clock edge.
- The observation is a property of the successor state, so the outputs are the decoded next state (Mealy). Registers commit that state on the edge.
- Adds an auto-closing door with a timeout counter and an optional fault-injection path.

## Interface

Parameters:
- `DOOR_TIMEOUT`, default 4: number of consecutive cycles the door may stay open (level OPEN) before it auto-closes; legal range 1..255.
- `TW`, default 8: width of the door timer; must hold `DOOR_TIMEOUT`.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `iup` in 1: agent vertical move; 1 = up, 0 = down.
- `iright` in 1: agent horizontal move; 1 = right, 0 = left.
- `fault_inj` in 1: fault request; exists only with `PASSAGEWAY_FAULT_INJECT_EN`.
- `controllable_zone0`..`controllable_zone3` out 1 each: one-hot zone of the successor state.
- `controllable_open` out 1: successor level is OPEN or DOORSTEP.
- `controllable_doorstep` out 1: successor level is DOORSTEP.
- `controllable_fault` out 1: successor state faulted.
- `at_goal` out 1: registered; current zone is 3 and not faulted.

## Operation

State:
- `zone` (0..3)
- `level` ∈ {CORRIDOR, OPEN, DOORSTEP}
- `timer` (TW bits)
- `fault` (sticky)

Next-state rules, evaluated in this priority order per level:
- CORRIDOR:
  - `iup=0` → OPEN, `timer`←0.
  - `iup=1` → stay. Never raise `open` when `iup=1` from CORRIDOR.
- OPEN:
  - `iup=1` → CORRIDOR.
  - else `iright=1` → DOORSTEP.
  - else if `timer==DOOR_TIMEOUT-1` → CORRIDOR (auto-close).
  - else stay, `timer`+1.
  - Zone never changes in OPEN.
- DOORSTEP:
  - `iright=1` and `zone<3` → `zone`+1, stay DOORSTEP.
  - `iright=1` and `zone==3` → stay (saturate).
  - `iright=0`, `iup=1` → OPEN, `timer`←0.
  - `iright=0`, `iup=0` → stay.
  - Zone never decreases.

Other rules:
- Zone outputs are always exactly one-hot.
- `timer` is held at 0 outside OPEN.

## Timing

- Outputs `controllable_*` are combinational from the current registers plus `iup`/`iright`. They equal the state that will be registered at the next posedge.
- No pipeline latency.
- No combinational path from outputs back to inputs.
- `at_goal` is registered and lags the corresponding `controllable_zone3` by one cycle.
- Reset (`rst=1` at posedge) sets `zone=0`, `level=CORRIDOR`, `timer=0`, `fault=0`, `at_goal=0`.
- While `rst` is high, outputs are forced to the reset decode: `zone0=1`, all other `controllable_*`=0. This holds regardless of `iup`/`iright`.
- Reset mid-episode (for example at DOORSTEP, zone 2) takes effect at that edge; there is no partial update.
- Auto-close and `iright=1` on the same cycle: DOORSTEP wins.
- `iup=1` in OPEN takes priority over both.

## Configuration

- Macro: `PASSAGEWAY_FAULT_INJECT_EN`.
- Defined:
  - `fault_inj` port exists.
  - `fault_inj=1` sets `fault` (sticky until `rst`).
  - `controllable_fault` goes high in the same cycle as the request (it is a successor-state property).
  - While faulted, zone advance from DOORSTEP is suppressed; level movement is unchanged.
- Undefined:
  - No `fault_inj` port.
  - `fault` register is removed.
  - `controllable_fault` is tied to 0.

## Structure

- Shared package `passageway_pkg`:
  - `level_t` enum (CORRIDOR=0, OPEN=1, DOORSTEP=2).
  - `zone_t` (2-bit).
  - `NZONES=4` and `GOAL_ZONE=3` constants.
  - Zone one-hot decode function.
- Sub-module `passageway_door_timer`: clear, increment and expiry compare against `DOOR_TIMEOUT`. Single instance.
- Top holds the next-state logic, the state registers and the output decode.

## Test plan

- Reset, then `iup=1` for 3 cycles → `zone0=1`, `open=0`, `doorstep=0` every cycle.
- From CORRIDOR: `iup=0,iright=0`, then `iup=0,iright=1`, then `iright=1` ×3 → `open=1`; then `doorstep=1`; then zones 1, 2, 3. `at_goal=1` one cycle after `zone3`. A further `iright=1` keeps `zone3=1`.
- With `DOOR_TIMEOUT=4`: enter OPEN, then hold `iup=0,iright=0` → `open` drops on the 4th hold cycle. On that expiry cycle, `iright=1` yields `doorstep=1` instead.
- At DOORSTEP zone 2: apply `rst` → same cycle `zone0=1`, `open=0`; next cycle `at_goal=0`.
- With `PASSAGEWAY_FAULT_INJECT_EN`: at DOORSTEP zone 1, pulse `fault_inj`, then `iright=1` ×2 → `fault=1` immediately and stays high; zone stays 1.
- Drive all 4 combinations of `iup`/`iright` from each level and zone → outputs match the next-state rules and are always one-hot.
